// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared forwarding select codes and default datapath widths.
package pipeline_pkg;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_REG_W   = 5;
    localparam int DEF_ALUOP_W = 4;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10,
        FWD_ALT   = 2'b11
    } fwd_sel_e;
endpackage

// File: rtl/id_ex_stage_fwd_select.sv
// fwd_select: compares one source index against the EX and MEM destinations.
module fwd_select
    import pipeline_pkg::*;
#(
    parameter int REG_W = DEF_REG_W
) (
    input  logic [REG_W-1:0] i_idx,
    input  logic             i_ex_wr,
    input  logic [REG_W-1:0] i_ex_dst,
    input  logic             i_mem_wr,
    input  logic [REG_W-1:0] i_mem_dst,
    output logic [1:0]       o_sel
);
    // EX wins over MEM: it holds the younger write to the same register.
    assign o_sel = (i_ex_wr  && i_ex_dst  != '0 && i_ex_dst  == i_idx) ? FWD_EXMEM :
                   (i_mem_wr && i_mem_dst != '0 && i_mem_dst == i_idx) ? FWD_MEMWB : FWD_REG;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with registered forwarding selects and load-use bubbles.
// Optional FWD_STATS_EN adds saturating forward/bubble counters.
module id_ex_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int REG_W   = DEF_REG_W,
    parameter int ALUOP_W = DEF_ALUOP_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic               id_valid,
    input  logic [DATA_W-1:0]  id_pc4,
    input  logic [DATA_W-1:0]  id_rs_data,
    input  logic [DATA_W-1:0]  id_rt_data,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic [REG_W-1:0]   id_rs,
    input  logic [REG_W-1:0]   id_rt,
    input  logic [REG_W-1:0]   id_dst,
    input  logic               id_uses_rs,
    input  logic               id_uses_rt,
    input  logic               id_use_imm,
    input  logic               id_link,
    input  logic               id_reg_write,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic [ALUOP_W-1:0] id_alu_op,
    input  logic               mem_reg_write,
    input  logic [REG_W-1:0]   mem_dst,
    output logic               hazard_stall,
    output logic               ex_valid,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic [DATA_W-1:0]  ex_pc4,
    output logic [DATA_W-1:0]  ex_rs_data,
    output logic [DATA_W-1:0]  ex_rt_data,
    output logic [DATA_W-1:0]  ex_imm,
    output logic [REG_W-1:0]   ex_dst,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic [1:0]         ex_fwd_a,
    output logic [1:0]         ex_fwd_b,
    output logic [1:0]         ex_fwd_st
`ifdef FWD_STATS_EN
    ,
    output logic [15:0]        fwd_count,
    output logic [15:0]        bubble_count
`endif
);
    logic               r_valid, r_reg_write, r_mem_read, r_mem_write;
    logic [DATA_W-1:0]  r_pc4, r_rs_data, r_rt_data, r_imm;
    logic [REG_W-1:0]   r_dst;
    logic [ALUOP_W-1:0] r_alu_op;
    logic [1:0]         r_fwd_a, r_fwd_b, r_fwd_st;
    logic [1:0]         w_sel_rs, w_sel_rt, w_a, w_b, w_st;
    logic               w_ex_wr, w_bubble, w_advance;

    assign w_ex_wr = r_valid & r_reg_write;

    fwd_select #(.REG_W(REG_W)) u_sel_rs (
        .i_idx(id_rs), .i_ex_wr(w_ex_wr), .i_ex_dst(r_dst),
        .i_mem_wr(mem_reg_write), .i_mem_dst(mem_dst), .o_sel(w_sel_rs)
    );

    fwd_select #(.REG_W(REG_W)) u_sel_rt (
        .i_idx(id_rt), .i_ex_wr(w_ex_wr), .i_ex_dst(r_dst),
        .i_mem_wr(mem_reg_write), .i_mem_dst(mem_dst), .o_sel(w_sel_rt)
    );

    // An invalid ID slot must never present a nonzero select to EX.
    always_comb begin
        w_a  = !id_valid ? FWD_REG : id_link    ? FWD_ALT : id_uses_rs ? w_sel_rs : FWD_REG;
        w_b  = !id_valid ? FWD_REG : id_use_imm ? FWD_ALT : id_uses_rt ? w_sel_rt : FWD_REG;
        w_st = (id_valid && id_mem_write) ? w_sel_rt : FWD_REG;
    end

    assign hazard_stall = id_valid & r_valid & r_mem_read & (r_dst != '0) &
                          ((id_uses_rs & (r_dst == id_rs)) | (id_uses_rt & (r_dst == id_rt)));
    assign w_bubble     = flush | hazard_stall;
    assign w_advance    = !stall && !w_bubble;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_pc4       <= '0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_dst       <= '0;
            r_alu_op    <= '0;
            r_fwd_a     <= FWD_REG;
            r_fwd_b     <= FWD_REG;
            r_fwd_st    <= FWD_REG;
        end else if (!stall) begin
            if (w_bubble) begin
                r_valid     <= 1'b0;
                r_reg_write <= 1'b0;
                r_mem_read  <= 1'b0;
                r_mem_write <= 1'b0;
                r_fwd_a     <= FWD_REG;
                r_fwd_b     <= FWD_REG;
                r_fwd_st    <= FWD_REG;
            end else begin
                r_valid     <= id_valid;
                r_reg_write <= id_valid & id_reg_write;
                r_mem_read  <= id_valid & id_mem_read;
                r_mem_write <= id_valid & id_mem_write;
                r_pc4       <= id_pc4;
                r_rs_data   <= id_rs_data;
                r_rt_data   <= id_rt_data;
                r_imm       <= id_imm;
                r_dst       <= id_dst;
                r_alu_op    <= id_alu_op;
                r_fwd_a     <= w_a;
                r_fwd_b     <= w_b;
                r_fwd_st    <= w_st;
            end
        end
    end

    assign ex_valid     = r_valid;
    assign ex_reg_write = r_reg_write;
    assign ex_mem_read  = r_mem_read;
    assign ex_mem_write = r_mem_write;
    assign ex_pc4       = r_pc4;
    assign ex_rs_data   = r_rs_data;
    assign ex_rt_data   = r_rt_data;
    assign ex_imm       = r_imm;
    assign ex_dst       = r_dst;
    assign ex_alu_op    = r_alu_op;
    assign ex_fwd_a     = r_fwd_a;
    assign ex_fwd_b     = r_fwd_b;
    assign ex_fwd_st    = r_fwd_st;

`ifdef FWD_STATS_EN
    logic [15:0] r_fwd_cnt, r_bub_cnt;
    logic        w_fwd_any;

    // Codes 01 and 10 are exactly the ones with differing bits.
    assign w_fwd_any = (w_a[0] ^ w_a[1]) | (w_b[0] ^ w_b[1]) | (w_st[0] ^ w_st[1]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fwd_cnt <= '0;
            r_bub_cnt <= '0;
        end else if (!stall) begin
            if (w_advance && w_fwd_any && r_fwd_cnt != 16'hFFFF)
                r_fwd_cnt <= r_fwd_cnt + 16'd1;
            if (hazard_stall && r_bub_cnt != 16'hFFFF)
                r_bub_cnt <= r_bub_cnt + 16'd1;
        end
    end

    assign fwd_count    = r_fwd_cnt;
    assign bubble_count = r_bub_cnt;
`else
    logic w_unused;
    assign w_unused = w_advance;
`endif
endmodule
